spi_bus_monitor: RTL
====================

# spi_bus_monitor

Passive SPI bus monitor: a receive-only observer that sits on the wires between the SPI master and slave interfaces. It captures both directions of each frame (mosi and miso) without driving anything, and reports each complete frame with a one-cycle valid pulse. It also flags truncated frames and overruns. It is the reading end of the bus, used in system builds and benches as a protocol checker and traffic logger.

## Interface
Parameters:
- SPI_MAX_WIDTH_LOG, 4, log2 of the maximum frame width; data ports are 2**SPI_MAX_WIDTH_LOG bits.

Ports:
- clk  in  1  system clock; all logic is on the rising edge; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- sck  in  1  SPI clock as seen on the bus; asynchronous to clk; much slower than clk.
- cs  in  1  chip select, active low.
- mosi  in  1  master-to-slave data.
- miso  in  1  slave-to-master data.
- config_req  in  1  load config_data this cycle; honoured only in IDLE.
- config_data  in  SPI_MAX_WIDTH_LOG+2  configuration word:
  - [SPI_MAX_WIDTH_LOG-1:0]: frame length minus 1.
  - [SPI_MAX_WIDTH_LOG]: sample edge (0 = sck rising, 1 = sck falling).
  - [SPI_MAX_WIDTH_LOG+1]: bit order (0 = MSB first, 1 = LSB first).
- busy  out  1  high while a frame is being observed (state not IDLE).
- frame_valid  out  1  one-cycle pulse: a complete frame was captured.
- mosi_data  out  2**SPI_MAX_WIDTH_LOG  last complete mosi frame.
- miso_data  out  2**SPI_MAX_WIDTH_LOG  last complete miso frame.
- frame_error  out  1  one-cycle pulse: cs deasserted before the frame length was reached.
- overrun  out  1  sticky: extra sample edges arrived after the frame completed; cleared at the next frame start.
- frame_cnt  out  16  count of valid frames; wraps 16'hFFFF -> 0.

## Operation
- Input synchronisation:
  - sck, cs, mosi and miso each pass through 2-flop synchronisers; a third sck flop and a third cs flop feed edge detection.
  - All synchroniser flops reset to 0.
- Configuration registers:
  - Reset defaults: length 2**SPI_MAX_WIDTH_LOG, rising-edge sampling, MSB first.
  - config_req outside IDLE is ignored; the previous configuration is kept.
- Start condition:
  - A frame starts only on a cs falling edge observed after reset.
  - A frame already in progress when reset is released is ignored until cs goes high and falls again.
- State machine:
  - IDLE -> ACTIVE on a cs falling edge. Clear the bit counter, both shift registers and overrun.
  - ACTIVE, on each sample edge: capture synchronised mosi and miso into their shift registers; bit counter +1.
  - ACTIVE -> HOLD on the sample edge where bit counter == length-1. Load mosi_data and miso_data, pulse frame_valid, increment frame_cnt.
  - ACTIVE -> IDLE on a cs rising edge before completion. Pulse frame_error; mosi_data, miso_data and frame_cnt are unchanged.
  - HOLD, on any further sample edge: set overrun; data outputs are not changed.
  - HOLD -> IDLE on a cs rising edge.
  - A cs rising edge coinciding with the final sample edge counts as completion (frame_valid, no frame_error).
- Data alignment:
  - MSB first: shift left, new bit into bit 0. The frame occupies [length-1:0], and the first bit received is at bit length-1.
  - LSB first: the i-th received bit goes to bit i.
  - Bits above length-1 are always 0.
- Reset mid-frame: return to IDLE immediately with all outputs at reset values; no frame_valid and no frame_error.

## Timing
- Reset values: busy=0, frame_valid=0, frame_error=0, overrun=0, mosi_data=0, miso_data=0, frame_cnt=0.
- Edge latency: a raw sck or cs transition first sampled at clk edge k is acted on at edge k+2. The resulting outputs are visible after edge k+2.
- frame_valid and frame_error are exactly one clk wide.
- Data outputs are stable from the frame_valid edge until the next frame_valid or reset.
- busy rises 3 clk edges after the raw cs fall is first sampled, and falls likewise after the cs rise.
- Input constraint: sck half-period must be at least 4 clk periods.

## Test plan
- Default config, 16-bit frame, mosi 16'hA5C3, miso 16'h3C5A, MSB first on sck rising -> one frame_valid, mosi_data=16'hA5C3, miso_data=16'h3C5A, frame_cnt=1, frame_error=0.
- config_data={1,1,4'd7} (LSB first, falling edge, 8 bits), mosi bits sent LSB first for 8'h81 -> mosi_data=16'h0081, frame_valid once.
- Default config, cs raised after 9 sck edges -> frame_error pulse, no frame_valid, data and frame_cnt unchanged.
- 8-bit config, 10 sck edges before cs rises -> frame_valid after edge 8, overrun=1 until the next cs fall, mosi_data holds the 8-bit word.
- rst asserted mid-frame while cs is low, released with cs still low, more sck edges, then cs high and a new full frame -> no output during the aborted frame; the new frame is captured with frame_cnt=1.
- config_req asserted during ACTIVE with length 4 -> ignored, current 16-bit frame completes normally.

Source files
------------

// File: rtl/spi_bus_monitor.sv
// Passive SPI bus observer: captures mosi and miso frames without driving the bus,
// and reports complete frames, truncated frames and overruns.
module spi_bus_monitor #(
   parameter int SPI_MAX_WIDTH_LOG = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              sck,
   input  logic                              cs,
   input  logic                              mosi,
   input  logic                              miso,
   input  logic                              config_req,
   input  logic [SPI_MAX_WIDTH_LOG+1:0]      config_data,
   output logic                              busy,
   output logic                              frame_valid,
   output logic [(2**SPI_MAX_WIDTH_LOG)-1:0] mosi_data,
   output logic [(2**SPI_MAX_WIDTH_LOG)-1:0] miso_data,
   output logic                              frame_error,
   output logic                              overrun,
   output logic [15:0]                       frame_cnt
);

   localparam int W = 2**SPI_MAX_WIDTH_LOG;

   typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

   state_t                       state;
   logic                         sck_s1, sck_s2, sck_s3;
   logic                         cs_s1, cs_s2, cs_s3;
   logic                         mosi_s1, mosi_s2;
   logic                         miso_s1, miso_s2;
   logic [SPI_MAX_WIDTH_LOG-1:0] cfg_len;
   logic                         cfg_fall_edge;
   logic                         cfg_lsb_first;
   logic [SPI_MAX_WIDTH_LOG-1:0] bit_cnt;
   logic [W-1:0]                 mosi_shift, miso_shift;
   logic [W-1:0]                 mosi_next, miso_next;
   logic                         sck_rise, sck_fall, cs_rise, cs_fall;
   logic                         sample_edge, last_bit;

   // Synchronisers reset to 0, so a cs held low across reset never looks like a fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_s3 <= 1'b0;
         cs_s1 <= 1'b0; cs_s2 <= 1'b0; cs_s3 <= 1'b0;
         mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
         miso_s1 <= 1'b0; miso_s2 <= 1'b0;
      end else begin
         sck_s1 <= sck; sck_s2 <= sck_s1; sck_s3 <= sck_s2;
         cs_s1 <= cs; cs_s2 <= cs_s1; cs_s3 <= cs_s2;
         mosi_s1 <= mosi; mosi_s2 <= mosi_s1;
         miso_s1 <= miso; miso_s2 <= miso_s1;
      end
   end

   assign sck_rise    = sck_s2 & ~sck_s3;
   assign sck_fall    = ~sck_s2 & sck_s3;
   assign cs_rise     = cs_s2 & ~cs_s3;
   assign cs_fall     = ~cs_s2 & cs_s3;
   assign sample_edge = cfg_fall_edge ? sck_fall : sck_rise;
   assign last_bit    = (bit_cnt == cfg_len);

   always_comb begin
      mosi_next = mosi_shift;
      miso_next = miso_shift;
      if (cfg_lsb_first) begin
         mosi_next[bit_cnt] = mosi_s2;
         miso_next[bit_cnt] = miso_s2;
      end else begin
         mosi_next = {mosi_shift[W-2:0], mosi_s2};
         miso_next = {miso_shift[W-2:0], miso_s2};
      end
   end

   // A cs rise on the same cycle as the final sample edge completes the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cfg_len       <= '1;
         cfg_fall_edge <= 1'b0;
         cfg_lsb_first <= 1'b0;
         bit_cnt       <= '0;
         mosi_shift    <= '0;
         miso_shift    <= '0;
         busy          <= 1'b0;
         frame_valid   <= 1'b0;
         frame_error   <= 1'b0;
         overrun       <= 1'b0;
         mosi_data     <= '0;
         miso_data     <= '0;
         frame_cnt     <= '0;
      end else begin
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         case (state)
            IDLE: begin
               if (config_req) begin
                  cfg_len       <= config_data[SPI_MAX_WIDTH_LOG-1:0];
                  cfg_fall_edge <= config_data[SPI_MAX_WIDTH_LOG];
                  cfg_lsb_first <= config_data[SPI_MAX_WIDTH_LOG+1];
               end
               if (cs_fall) begin
                  state      <= ACTIVE;
                  busy       <= 1'b1;
                  bit_cnt    <= '0;
                  mosi_shift <= '0;
                  miso_shift <= '0;
                  overrun    <= 1'b0;
               end
            end
            ACTIVE: begin
               if (sample_edge && last_bit) begin
                  mosi_shift  <= mosi_next;
                  miso_shift  <= miso_next;
                  mosi_data   <= mosi_next;
                  miso_data   <= miso_next;
                  frame_valid <= 1'b1;
                  frame_cnt   <= frame_cnt + 16'd1;
                  if (cs_rise) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= HOLD;
                  end
               end else if (cs_rise) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  frame_error <= 1'b1;
               end else if (sample_edge) begin
                  mosi_shift <= mosi_next;
                  miso_shift <= miso_next;
                  bit_cnt    <= bit_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (sample_edge) begin
                  overrun <= 1'b1;
               end
               if (cs_rise) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
